// File: rtl/square_motion_pkg.sv
// Shared types and clamp-bound helpers for the square motion controller.
package square_motion_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    MOVE_X,
    MOVE_Y,
    PUBLISH
  } state_t;

  typedef logic [9:0] coord_t;

  // Centre limits that keep the whole square on screen.
  function automatic int bound_lo(input int size);
    return size;
  endfunction

  function automatic int bound_hi(input int pixels, input int size);
    return pixels - 1 - size;
  endfunction

endpackage

// File: rtl/square_axis_stepper.sv
// One axis of square motion: latched key direction, optional acceleration
// (enabled by SQUARE_MOTION_ACCEL_EN), and the clamped shadow coordinate.
module square_axis_stepper
  import square_motion_pkg::*;
#(
  parameter int PIXELS       = 640,
  parameter int SQUARE_SIZE  = 10,
  parameter int INIT         = 320,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       neg_key,
  input  logic       pos_key,
  input  logic       step_en,
  output logic [9:0] pos
);

  localparam logic signed [10:0] LO = 11'(bound_lo(SQUARE_SIZE));
  localparam logic signed [10:0] HI = 11'(bound_hi(PIXELS, SQUARE_SIZE));

  logic              dir_neg;
  logic              dir_pos;
  coord_t            shadow;
  logic signed [10:0] step;
  logic signed [10:0] delta;
  logic signed [10:0] target;

  function automatic logic [9:0] clamp_pos(input logic signed [10:0] v);
    if (v < LO) return LO[9:0];
    else if (v > HI) return HI[9:0];
    else return v[9:0];
  endfunction

  // Opposing keys cancel, so at most one direction flag is ever set.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_neg <= 1'b0;
      dir_pos <= 1'b0;
    end else if (sample_en) begin
      dir_neg <= neg_key & ~pos_key;
      dir_pos <= pos_key & ~neg_key;
    end
  end

`ifdef SQUARE_MOTION_ACCEL_EN
  localparam int SPD_W  = $clog2(MAX_SPEED + 1);
  localparam int HOLD_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  logic [SPD_W-1:0]  speed;
  logic [HOLD_W-1:0] hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      speed <= SPD_W'(1);
      hold  <= '0;
    end else if (step_en) begin
      if (dir_neg | dir_pos) begin
        if (hold == HOLD_W'(ACCEL_FRAMES - 1)) begin
          hold <= '0;
          if (speed < SPD_W'(MAX_SPEED)) speed <= speed + SPD_W'(1);
        end else begin
          hold <= hold + HOLD_W'(1);
        end
      end else begin
        speed <= SPD_W'(1);
        hold  <= '0;
      end
    end
  end

  assign step = $signed(11'(speed));
`else
  // Fixed unit step; a degenerate zero speed/frame configuration freezes motion.
  assign step = (MAX_SPEED > 0 && ACCEL_FRAMES > 0) ? 11'sd1 : 11'sd0;
`endif

  always_comb begin
    delta = '0;
    if (dir_pos) delta = step;
    else if (dir_neg) delta = -step;
  end

  assign target = $signed({1'b0, shadow}) + delta;

  always_ff @(posedge clk) begin
    if (reset) shadow <= 10'(INIT);
    else if (step_en) shadow <= clamp_pos(target);
  end

  assign pos = shadow;

endmodule

// File: rtl/square_motion_ctrl.sv
// Per-frame square position update: SAMPLE keys, MOVE_X, MOVE_Y, PUBLISH.
// Define SQUARE_MOTION_ACCEL_EN to enable per-axis acceleration.
module square_motion_ctrl
  import square_motion_pkg::*;
#(
  parameter int H_PIXELS     = 640,
  parameter int V_PIXELS     = 480,
  parameter int SQUARE_SIZE  = 10,
  parameter int INIT_X       = 320,
  parameter int INIT_Y       = 240,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       u_arr,
  input  logic       d_arr,
  input  logic       l_arr,
  input  logic       r_arr,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       pos_valid,
  output logic       busy,
  output logic       overrun
);

  state_t state;
  state_t state_nxt;
  logic   sample_en;
  logic   step_x;
  logic   step_y;
  logic   publish;
  coord_t shadow_x;
  coord_t shadow_y;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = MOVE_X;
      MOVE_X:  state_nxt = MOVE_Y;
      MOVE_Y:  state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    sample_en = (state == SAMPLE);
    step_x    = (state == MOVE_X);
    step_y    = (state == MOVE_Y);
    publish   = (state == PUBLISH);
  end

  square_axis_stepper #(
    .PIXELS      (H_PIXELS),
    .SQUARE_SIZE (SQUARE_SIZE),
    .INIT        (INIT_X),
    .MAX_SPEED   (MAX_SPEED),
    .ACCEL_FRAMES(ACCEL_FRAMES)
  ) u_axis_x (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .neg_key  (l_arr),
    .pos_key  (r_arr),
    .step_en  (step_x),
    .pos      (shadow_x)
  );

  square_axis_stepper #(
    .PIXELS      (V_PIXELS),
    .SQUARE_SIZE (SQUARE_SIZE),
    .INIT        (INIT_Y),
    .MAX_SPEED   (MAX_SPEED),
    .ACCEL_FRAMES(ACCEL_FRAMES)
  ) u_axis_y (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .neg_key  (u_arr),
    .pos_key  (d_arr),
    .step_en  (step_y),
    .pos      (shadow_y)
  );

  // Published position only moves on PUBLISH, so a frame never sees a half update.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x     <= 10'(INIT_X);
      pos_y     <= 10'(INIT_Y);
      pos_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pos_valid <= publish;
      overrun   <= frame_tick & busy;
      if (publish) begin
        pos_x <= shadow_x;
        pos_y <= shadow_y;
      end
    end
  end

endmodule
